// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Shares the single write port of a register-file FIFO between NUM_REQ producers.
//   A requester wins the port for a burst of up to BURST_MAX words. The owner is
//   chosen round-robin, and the FIFO full flag stalls writes in the same cycle.
//
//   Build option: define FIFO_WR_ARBITER_FIXED_PRIO_EN to select fixed priority,
//   where the lowest set index wins and there is no rotating pointer.
//
// Ports
//   clk          clock, all state updates on posedge
//   reset        synchronous, active-high
//   req          per-requester level request
//   wdata        requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH]
//   full         FIFO full flag, used combinationally
//   grant        one-hot current owner, registered, zero when idle
//   ack          one-hot strobe, owner's word is written this cycle
//   fifo_wr      FIFO write request
//   fifo_w_data  word presented to the FIFO, zero when idle
//   busy         high while a burst is in progress
module fifo_wr_arbiter #(
   parameter int unsigned NUM_REQ    = 4,
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned BURST_MAX  = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
   input  logic                          full,
   output logic [NUM_REQ-1:0]            grant,
   output logic [NUM_REQ-1:0]            ack,
   output logic                          fifo_wr,
   output logic [DATA_WIDTH-1:0]         fifo_w_data,
   output logic                          busy
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);
   localparam int unsigned CNT_W = $clog2(BURST_MAX + 1);

   typedef enum logic {StIdle, StXfer} state_e;

   state_e             state_q;
   logic [IDX_W-1:0]   owner_q;
   logic [CNT_W-1:0]   count_q;
   logic [NUM_REQ-1:0] grant_q;
   logic               busy_q;
   logic [IDX_W-1:0]   win_idx;
   logic               win_found;

`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
   // Descending scan so the lowest set index is the last assignment and wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req[IDX_W'(i)]) begin
            win_found = 1'b1;
            win_idx   = IDX_W'(i);
         end
      end
   end
`else
   logic [IDX_W-1:0] rr_ptr_q;
   logic [IDX_W-1:0] cand;

   // Scan offsets from the far end back to rr_ptr so the nearest set bit at or
   // after rr_ptr (modulo NUM_REQ) is the final assignment.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
         cand = IDX_W'((int'(rr_ptr_q) + k) % int'(NUM_REQ));
         if (req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= StIdle;
         owner_q  <= '0;
         count_q  <= '0;
         grant_q  <= '0;
         busy_q   <= 1'b0;
`ifndef FIFO_WR_ARBITER_FIXED_PRIO_EN
         rr_ptr_q <= '0;
`endif
      end else begin
         case (state_q)
            StIdle: begin
               if (win_found) begin
                  state_q  <= StXfer;
                  owner_q  <= win_idx;
                  count_q  <= '0;
                  grant_q  <= NUM_REQ'(1) << win_idx;
                  busy_q   <= 1'b1;
`ifndef FIFO_WR_ARBITER_FIXED_PRIO_EN
                  // Explicit wrap: NUM_REQ need not be a power of two.
                  rr_ptr_q <= (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
`endif
               end
            end
            StXfer: begin
               if (!req[owner_q]) begin
                  state_q <= StIdle;
                  count_q <= '0;
                  grant_q <= '0;
                  busy_q  <= 1'b0;
               end else if (!full) begin
                  if (count_q + 1'b1 == CNT_W'(BURST_MAX)) begin
                     state_q <= StIdle;
                     count_q <= '0;
                     grant_q <= '0;
                     busy_q  <= 1'b0;
                  end else begin
                     count_q <= count_q + 1'b1;
                  end
               end
               // full with req held: stall, nothing changes
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign grant       = grant_q;
   assign busy        = busy_q;
   assign fifo_wr     = (state_q == StXfer) && req[owner_q] && !full;
   assign ack         = grant_q & {NUM_REQ{fifo_wr}};
   assign fifo_w_data = (state_q == StXfer) ? wdata[int'(owner_q)*DATA_WIDTH +: DATA_WIDTH]
                                            : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: directed scenarios plus randomized traffic
// checked against a cycle-level behavioural model of the arbitration rules.
module tb_fifo_wr_arbiter;

   localparam int NUM_REQ    = 4;
   localparam int DATA_WIDTH = 8;
   localparam int BURST_MAX  = 4;
   localparam int VEC_W      = 2*NUM_REQ + DATA_WIDTH + 2;

   logic                          clk = 1'b0;
   logic                          reset;
   logic [NUM_REQ-1:0]            req;
   logic [NUM_REQ*DATA_WIDTH-1:0] wdata;
   logic                          full;
   logic [NUM_REQ-1:0]            grant;
   logic [NUM_REQ-1:0]            ack;
   logic                          fifo_wr;
   logic [DATA_WIDTH-1:0]         fifo_w_data;
   logic                          busy;

   int n_cmp  = 0;
   int n_fail = 0;

   // model state
   bit m_busy;
   int m_owner;
   int m_ptr;
   int m_cnt;

   fifo_wr_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_WIDTH(DATA_WIDTH),
      .BURST_MAX (BURST_MAX)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .req        (req),
      .wdata      (wdata),
      .full       (full),
      .grant      (grant),
      .ack        (ack),
      .fifo_wr    (fifo_wr),
      .fifo_w_data(fifo_w_data),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Expected {grant, ack, fifo_wr, fifo_w_data, busy} for the current cycle.
   function automatic logic [VEC_W-1:0] model_out();
      logic [NUM_REQ-1:0]    g;
      logic [NUM_REQ-1:0]    a;
      logic                  w;
      logic [DATA_WIDTH-1:0] d;
      g = '0; a = '0; w = 1'b0; d = '0;
      if (m_busy) begin
         g = NUM_REQ'(1) << m_owner;
         w = req[m_owner] && !full;
         a = w ? g : '0;
         d = wdata[m_owner*DATA_WIDTH +: DATA_WIDTH];
      end
      return {g, a, w, d, m_busy};
   endfunction

   function automatic void model_step();
      int win;
      if (reset) begin
         m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      end else if (!m_busy) begin
         win = -1;
         for (int k = 0; k < NUM_REQ; k++) begin
`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
            int idx = k;
`else
            int idx = (m_ptr + k) % NUM_REQ;
`endif
            if (req[idx] && win < 0) win = idx;
         end
         if (win >= 0) begin
            m_busy = 1; m_owner = win; m_cnt = 0;
            m_ptr = (win + 1) % NUM_REQ;
         end
      end else if (!req[m_owner]) begin
         m_busy = 0;
      end else if (!full) begin
         m_cnt++;
         if (m_cnt == BURST_MAX) m_busy = 0;
      end
   endfunction

   // Advance one clock; returns 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; req = '0; full = 1'b0; wdata = '0;
      tick();
      reset = 1'b0;
   endtask

   task automatic drain();
      req = '0; full = 1'b0;
      for (int i = 0; i < 8 && m_busy; i++) tick();
      tick();
   endtask

   task automatic test_reset();
      do_reset();
      for (int c = 0; c < 5; c++) begin
         #1;
         n_cmp++;
         if (grant !== 4'b0000 || fifo_wr !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle cyc%0d: got grant=%b wr=%b busy=%b want 0000/0/0",
                     c, grant, fifo_wr, busy);
         end
         tick();
      end
   endtask

   task automatic test_single();
      do_reset();
      req = 4'b0100;
      wdata[2*DATA_WIDTH +: DATA_WIDTH] = 8'h10;
      #1;
      n_cmp++;
      if (grant !== 4'b0000) begin
         n_fail++; $display("FAIL single_pre_grant: got %b want 0000", grant);
      end
      tick();
      for (int k = 0; k < BURST_MAX; k++) begin
         #1;
         n_cmp++;
         if (grant !== 4'b0100 || ack !== 4'b0100 || fifo_w_data !== 8'(8'h10 + k)) begin
            n_fail++;
            $display("FAIL single_word%0d: got grant=%b ack=%b data=%h want 0100/0100/%h",
                     k, grant, ack, fifo_w_data, 8'(8'h10 + k));
         end
         tick();
         wdata[2*DATA_WIDTH +: DATA_WIDTH] = 8'(8'h11 + k);
      end
      #1;
      n_cmp++;
      if (busy !== 1'b0 || grant !== 4'b0000 || fifo_wr !== 1'b0) begin
         n_fail++;
         $display("FAIL single_bubble: got busy=%b grant=%b wr=%b want 0/0000/0",
                  busy, grant, fifo_wr);
      end
      tick();
      #1;
      n_cmp++;
      if (grant !== 4'b0100) begin
         n_fail++; $display("FAIL single_regrant: got %b want 0100", grant);
      end
      drain();
   endtask

   task automatic test_all_high();
      int exp_own;
      do_reset();
      req = 4'b1111;
      for (int r = 0; r < NUM_REQ; r++) wdata[r*DATA_WIDTH +: DATA_WIDTH] = 8'(8'h30 + r);
      for (int b = 0; b < 5; b++) begin
`ifdef FIFO_WR_ARBITER_FIXED_PRIO_EN
         exp_own = 0;
`else
         exp_own = b % NUM_REQ;
`endif
         #1;
         n_cmp++;
         if (busy !== 1'b0 || grant !== 4'b0000) begin
            n_fail++;
            $display("FAIL all_bubble%0d: got busy=%b grant=%b want 0/0000", b, busy, grant);
         end
         tick();
         for (int w = 0; w < BURST_MAX; w++) begin
            #1;
            n_cmp++;
            if (grant !== 4'(1 << exp_own) || ack !== 4'(1 << exp_own) ||
                fifo_w_data !== 8'(8'h30 + exp_own)) begin
               n_fail++;
               $display("FAIL all_burst%0d_w%0d: got grant=%b ack=%b data=%h want owner %0d",
                        b, w, grant, ack, fifo_w_data, exp_own);
            end
            tick();
         end
      end
      drain();
   endtask

   task automatic test_stall();
      int words;
      int cyc;
      do_reset();
      words = 0;
      req = 4'b0010;
      wdata[1*DATA_WIDTH +: DATA_WIDTH] = 8'hA0;
      tick();
      cyc = 0;
      while (words < BURST_MAX && cyc < 20) begin
         full = (words == 2 && cyc >= 2 && cyc < 5);
         #1;
         if (full) begin
            n_cmp++;
            if (ack !== 4'b0000 || fifo_wr !== 1'b0 || grant !== 4'b0010) begin
               n_fail++;
               $display("FAIL stall_cyc%0d: got ack=%b wr=%b grant=%b want 0000/0/0010",
                        cyc, ack, fifo_wr, grant);
            end
         end else begin
            n_cmp++;
            if (ack !== 4'b0010 || fifo_w_data !== 8'(8'hA0 + words)) begin
               n_fail++;
               $display("FAIL stall_word%0d: got ack=%b data=%h want 0010/%h",
                        words, ack, fifo_w_data, 8'(8'hA0 + words));
            end
         end
         if (fifo_wr) words++;
         tick();
         wdata[1*DATA_WIDTH +: DATA_WIDTH] = 8'(8'hA0 + words);
         cyc++;
      end
      full = 1'b0;
      #1;
      n_cmp++;
      if (words != BURST_MAX || cyc != BURST_MAX + 3 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_total: got words=%0d cycles=%0d busy=%b want 4/7/0",
                  words, cyc, busy);
      end
      drain();
   endtask

   task automatic test_drop();
      do_reset();
      req = 4'b1000;
      wdata = {8'hD3, 8'h00, 8'h00, 8'hD0};
      tick();
      req = 4'b1001;
      for (int w = 0; w < 2; w++) begin
         #1;
         n_cmp++;
         if (ack !== 4'b1000 || fifo_w_data !== 8'hD3) begin
            n_fail++;
            $display("FAIL drop_word%0d: got ack=%b data=%h want 1000/d3", w, ack, fifo_w_data);
         end
         tick();
      end
      req = 4'b0001;
      #1;
      n_cmp++;
      if (ack !== 4'b0000 || fifo_wr !== 1'b0) begin
         n_fail++; $display("FAIL drop_release: got ack=%b wr=%b want 0000/0", ack, fifo_wr);
      end
      tick();
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin
         n_fail++; $display("FAIL drop_idle: got busy=%b want 0", busy);
      end
      tick();
      #1;
      n_cmp++;
      if (grant !== 4'b0001) begin
         n_fail++; $display("FAIL drop_next: got grant=%b want 0001", grant);
      end
      drain();
   endtask

   task automatic test_reset_mid();
      do_reset();
      req = 4'b0100;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req = 4'b1111;
      #1;
      n_cmp++;
      if (grant !== 4'b0000 || fifo_wr !== 1'b0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_idle: got grant=%b wr=%b busy=%b want 0000/0/0",
                  grant, fifo_wr, busy);
      end
      tick();
      #1;
      n_cmp++;
      if (grant !== 4'b0001) begin
         n_fail++; $display("FAIL rstmid_first: got grant=%b want 0001", grant);
      end
      drain();
   endtask

   task automatic test_random();
      logic [VEC_W-1:0] exp_v;
      logic [VEC_W-1:0] got_v;
      do_reset();
      for (int c = 0; c < 600; c++) begin
         reset = ($urandom_range(0, 99) == 0);
         req   = NUM_REQ'($urandom_range(0, 3) == 0 ? 0 : $urandom);
         full  = ($urandom_range(0, 3) == 0);
         wdata = $urandom;
         #1;
         exp_v = model_out();
         got_v = {grant, ack, fifo_wr, fifo_w_data, busy};
         n_cmp++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL random_cyc%0d: got %b want %b (req=%b full=%b)",
                     c, got_v, exp_v, req, full);
         end
         tick();
      end
      reset = 1'b0;
      drain();
   endtask

   initial begin
      reset = 1'b1; req = '0; full = 1'b0; wdata = '0;
      m_busy = 0; m_owner = 0; m_ptr = 0; m_cnt = 0;
      #1;
      test_reset();
      test_single();
      test_all_high();
      test_stall();
      test_drop();
      test_reset_mid();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin arbiter that shares the single write port of a register-file FIFO between NUM_REQ producers. Each grant covers a burst of up to BURST_MAX words, and the arbiter honours the FIFO `full` backpressure. It drives the FIFO's `wr` and write-data inputs and returns a per-requester accept strobe. It sits between the producer blocks and the FIFO controller/register-file pair.

## Interface
- NUM_REQ, default 4: number of requesters; 2 to 16.
- DATA_WIDTH, default 8: FIFO word width.
- BURST_MAX, default 4: maximum words accepted per grant; at least 1.

- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- req  in  NUM_REQ  request per requester, level-sensitive, one bit each.
- wdata  in  NUM_REQ*DATA_WIDTH  requester i's word in bits [i*DATA_WIDTH +: DATA_WIDTH].
- full  in  1  FIFO full flag.
- grant  out  NUM_REQ  one-hot current owner; all zero when idle.
- ack  out  NUM_REQ  one-hot, single cycle; the granted requester's word is written this cycle.
- fifo_wr  out  1  FIFO write request.
- fifo_w_data  out  DATA_WIDTH  word presented to the FIFO write port.
- busy  out  1  high in XFER.

## Operation
- FSM states: IDLE, XFER.
- IDLE, no req bits set:
  - stay in IDLE.
- IDLE, any req bit set:
  - Pick the winner W: scan indices rr_ptr, rr_ptr+1, … modulo NUM_REQ; the first set bit wins.
  - Register grant = onehot(W), rr_ptr <= (W+1) mod NUM_REQ, burst count <= 0, go to XFER.
- XFER combinational outputs:
  - fifo_wr = req[W] & ~full.
  - ack[W] = fifo_wr.
  - fifo_w_data = wdata slice W.
- XFER transitions:
  - Each cycle with fifo_wr=1: count increments.
  - If req[W]=0 in a cycle: go to IDLE, no write.
  - If count+1 == BURST_MAX in a write cycle: go to IDLE.
  - full=1 with req[W]=1: stall; stay in XFER, count unchanged, no ack.
- In IDLE, fifo_wr, ack, grant and busy are all 0, and fifo_w_data = 0.
- Count width is $clog2(BURST_MAX+1). rr_ptr width is $clog2(NUM_REQ). Wrap-around is explicit modulo NUM_REQ, which is not required to be a power of 2.
- Requesters are not granted mid-burst. Requests arriving during XFER wait until the next IDLE.
- The arbiter never writes when full=1. Empty handling belongs to the reader side and is outside this block.

## Timing
- Reset values: state=IDLE, rr_ptr=0, count=0, grant=0, ack=0, fifo_wr=0, fifo_w_data=0, busy=0.
- Request latency: req rises at edge N (sampled in IDLE), grant is valid after edge N+1, and the first write can occur in cycle N+1.
- Burst cadence: one word per cycle while req[W]=1 and full=0.
- Release costs one IDLE cycle. Back-to-back bursts therefore have one bubble cycle between them.
- full is used combinationally in the same cycle. The write occurs in the cycle full is low, with no added latency.
- Reset during XFER: the next cycle is IDLE with the reset values above. The partially transferred burst is abandoned; already-acked words remain in the FIFO.
- req and full are treated as synchronous to clk.

## Configuration
- FIFO_WR_ARBITER_FIXED_PRIO_EN undefined (default): round-robin as described.
- FIFO_WR_ARBITER_FIXED_PRIO_EN defined:
  - Winner is the lowest-index set req bit; rr_ptr is not implemented.
  - All other behaviour, including bursts, stalls and release, is unchanged.

## Test plan
- Reset, then req=4'b0000 for 5 cycles:
  - grant=0, fifo_wr=0 and busy=0 throughout.
- Single requester, NUM_REQ=4, BURST_MAX=4, full=0, req[2] held high with wdata[2] incrementing 0x10,0x11,…:
  - grant=4'b0100 one cycle after req.
  - Exactly 4 acks, writing 0x10–0x13.
  - Then one IDLE cycle, then a new grant to requester 2.
- All four req high continuously:
  - Grant order is 0,1,2,3,0.
  - Each burst is 4 words, with one bubble between bursts.
- Requester 1 granted, full asserted for 3 cycles mid-burst after word 2:
  - No ack and count held during those 3 cycles.
  - Words 3–4 follow once full drops.
  - Total of 4 writes and no data loss.
- Requester 3 drops req after 2 words:
  - Release to IDLE with only 2 acks.
  - rr_ptr=0, so a waiting requester 0 wins next.
- Reset asserted mid-burst after 1 word:
  - Next cycle grant=0 and fifo_wr=0.
  - After release with req=4'b1111, requester 0 is granted first.
  - With FIFO_WR_ARBITER_FIXED_PRIO_EN defined, the all-high test grants requester 0 on every burst.
